// File: rtl/fft_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_gen_if
// Description : Beat stream from the FFT address sequencer to the sample RAM /
//               twiddle ROM consumer. One beat = {addr_a, addr_b, twiddle}
//               plus phase/stage tags, transferred on out_valid & out_ready.
//   Ports (master = sequencer side):
//     out_valid      beat present
//     out_ready      consumer accepts the beat (driven by slave)
//     load_phase     beat belongs to the bit-reversed LOAD pass
//     stage          butterfly stage (0 during LOAD)
//     addr_a/addr_b  LOAD: bitrev(idx)/idx; COMPUTE: top/bottom address
//     twiddle        twiddle ROM index (0 during LOAD)
//     last_in_stage  final beat of the LOAD pass or of a stage
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_addr_gen_if #(
    parameter int LOG2N = 4
);
    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;

    logic             out_valid;
    logic             out_ready;
    logic             load_phase;
    logic [SW-1:0]    stage;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] twiddle;
    logic             last_in_stage;

    modport master (
        output out_valid,
        output load_phase,
        output stage,
        output addr_a,
        output addr_b,
        output twiddle,
        output last_in_stage,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  load_phase,
        input  stage,
        input  addr_a,
        input  addr_b,
        input  twiddle,
        input  last_in_stage,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_gen
// Description : Self-running radix-2 in-place DIT FFT address sequencer.
//               After start it optionally emits a bit-reversed LOAD pass
//               (N beats), then every butterfly of every stage
//               (LOG2N * N/2 beats) on a valid/ready stream, then pulses
//               done for one cycle.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      begin a sequence (sampled only while idle)
//     skip_load  sampled with start; 1 = go straight to COMPUTE
//     bus        fft_addr_gen_if.master beat stream
//     busy       high during LOAD and COMPUTE
//     done       one-cycle pulse after the final COMPUTE beat is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen #(
    parameter int LOG2N = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic          skip_load,
    fft_addr_gen_if.master     bus,
    output logic               busy,
    output logic               done
);

    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;

    localparam logic [LOG2N-1:0] c_last_idx = '1;              // N-1
    localparam logic [LOG2N-2:0] c_last_j   = '1;              // N/2-1
    localparam logic [SW-1:0]    c_last_s   = SW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] c_one      = LOG2N'(1);
    localparam logic [LOG2N-2:0] c_one_j    = (LOG2N-1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    // Shared beat counter: idx (LOG2N bits) in LOAD, j (low LOG2N-1 bits)
    // in COMPUTE. Only one of the two passes is ever active.
    logic [LOG2N-1:0] cnt_q,   cnt_d;
    logic [SW-1:0]    stage_q, stage_d;

    // ------------------------------------------------------------------
    // Counter decode
    // ------------------------------------------------------------------
    logic [LOG2N-2:0] w_j;
    logic [LOG2N-1:0] w_h;
    logic [LOG2N-2:0] w_mask;
    logic [LOG2N-2:0] w_pos;
    logic [LOG2N-2:0] w_grp_bits;
    logic [LOG2N-1:0] w_cmp_a;
    logic [LOG2N-1:0] w_cmp_b;
    logic [LOG2N-2:0] w_tw;
    logic [LOG2N-1:0] w_rev;

    assign w_j = cnt_q[LOG2N-2:0];
    assign w_h = c_one << stage_q;

    // Mask of the low s bits of j. In the last stage 1<<s overflows the
    // (LOG2N-1)-bit width to zero, and 0-1 gives the all-ones mask needed.
    assign w_mask     = (c_one_j << stage_q) - c_one_j;
    assign w_pos      = w_j & w_mask;
    assign w_grp_bits = w_j & ~w_mask;

    // grp*2h + pos is j with a zero inserted at bit position s: the group
    // bits move up by one, the position bits stay put.
    assign w_cmp_a = {w_grp_bits, 1'b0} | {1'b0, w_pos};
    assign w_cmp_b = w_cmp_a | w_h;

    // pos < 2**s, so shifting by LOG2N-1-s always fits in LOG2N-1 bits.
    assign w_tw = w_pos << (c_last_s - stage_q);

    always_comb begin
        w_rev = '0;
        for (int k = 0; k < LOG2N; k++) begin
            w_rev[k] = cnt_q[LOG2N-1-k];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Counters move only when a beat is accepted, so a
    // stalled beat keeps every output stable.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = skip_load ? ST_COMPUTE : ST_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end

            ST_LOAD: begin
                if (bus.out_ready) begin
                    if (cnt_q == c_last_idx) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end

            ST_COMPUTE: begin
                if (bus.out_ready) begin
                    if (w_j == c_last_j) begin
                        cnt_d = '0;
                        if (stage_q == c_last_s) begin
                            state_d = ST_DONE;
                            stage_d = '0;
                        end else begin
                            stage_d = stage_q + SW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: everything is zero outside LOAD/COMPUTE, so an
    // asynchronous reset clears the outputs without waiting for a clock.
    // ------------------------------------------------------------------
    logic             w_valid;
    logic             w_load;
    logic [SW-1:0]    w_stage;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [LOG2N-2:0] w_twiddle;
    logic             w_last;

    always_comb begin
        w_valid   = 1'b0;
        w_load    = 1'b0;
        w_stage   = '0;
        w_addr_a  = '0;
        w_addr_b  = '0;
        w_twiddle = '0;
        w_last    = 1'b0;

        case (state_q)
            ST_LOAD: begin
                w_valid  = 1'b1;
                w_load   = 1'b1;
                w_addr_a = w_rev;
                w_addr_b = cnt_q;
                w_last   = (cnt_q == c_last_idx);
            end
            ST_COMPUTE: begin
                w_valid   = 1'b1;
                w_stage   = stage_q;
                w_addr_a  = w_cmp_a;
                w_addr_b  = w_cmp_b;
                w_twiddle = w_tw;
                w_last    = (w_j == c_last_j);
            end
            default: begin
            end
        endcase
    end

    assign bus.out_valid     = w_valid;
    assign bus.load_phase    = w_load;
    assign bus.stage         = w_stage;
    assign bus.addr_a        = w_addr_a;
    assign bus.addr_b        = w_addr_b;
    assign bus.twiddle       = w_twiddle;
    assign bus.last_in_stage = w_last;

    assign busy = w_valid;
    assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_addr_gen
// Description : Directed self-checking bench for fft_addr_gen. Builds with
//               LOG2N = 4 (main unit), 2 and 8 (size boundaries).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start4, skip4, busy4, done4;
    logic start2, skip2, busy2, done2;
    logic start8, skip8, busy8, done8;

    fft_addr_gen_if #(.LOG2N(4)) bus4 ();
    fft_addr_gen_if #(.LOG2N(2)) bus2 ();
    fft_addr_gen_if #(.LOG2N(8)) bus8 ();

    fft_addr_gen #(.LOG2N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .skip_load(skip4),
        .bus(bus4), .busy(busy4), .done(done4));
    fft_addr_gen #(.LOG2N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .skip_load(skip2),
        .bus(bus2), .busy(busy2), .done(done2));
    fft_addr_gen #(.LOG2N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .skip_load(skip8),
        .bus(bus8), .busy(busy8), .done(done8));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // beat packing: {ld, last, stage[1:0], a[3:0], b[3:0], tw[2:0]}
    function automatic logic [31:0] pack4(input logic ld, input logic lst,
                                          input logic [1:0] st, input logic [3:0] a,
                                          input logic [3:0] b, input logic [2:0] tw);
        return {17'd0, ld, lst, st, a, b, tw};
    endfunction

    function automatic logic [31:0] cur4();
        return pack4(bus4.load_phase, bus4.last_in_stage, bus4.stage,
                     bus4.addr_a, bus4.addr_b, bus4.twiddle);
    endfunction

    // Reference beat lists for N=16, written as group/position loops
    logic [31:0] exp_full[$];
    logic [31:0] exp_skip[$];

    task automatic build_exp();
        logic [3:0] r;
        int idx;
        for (int i = 0; i < 16; i++) begin
            idx = i;
            for (int k = 0; k < 4; k++) r[k] = idx[3-k];
            exp_full.push_back(pack4(1'b1, 1'(i == 15), 2'd0, r, 4'(i), 3'd0));
        end
        for (int s = 0; s < 4; s++) begin
            int h;
            h = 1 << s;
            for (int g = 0; g < 8 / h; g++) begin
                for (int p = 0; p < h; p++) begin
                    int a, j;
                    logic [31:0] bt;
                    a  = g * 2 * h + p;
                    j  = g * h + p;
                    bt = pack4(1'b0, 1'(j == 7), 2'(s), 4'(a), 4'(a + h), 3'(p * (8 / h)));
                    exp_full.push_back(bt);
                    exp_skip.push_back(bt);
                end
            end
        end
    endtask

    // Results of the last collect4 run
    logic [31:0] got4[$];
    int first_v, last_v, done_cyc, n_done, n_valid, stall_bad, busy_bad;

    // Entered just after a negedge (cycle 0). Pulses start, then samples
    // each negedge until done is seen or the budget runs out.
    task automatic collect4(input bit skip, input bit rnd, input bit busy_start,
                            input bit start_in_done);
        logic [31:0] prev;
        bit prev_stall;
        int c;
        got4.delete();
        first_v = -1; last_v = -1; done_cyc = -1;
        n_done = 0; n_valid = 0; stall_bad = 0; busy_bad = 0;
        prev_stall = 1'b0; prev = '0;
        skip4 = skip; start4 = 1'b1; bus4.out_ready = 1'b1;
        c = 0;
        while (done_cyc < 0 && c < 400) begin
            @(negedge clk);
            c++;
            start4 = busy_start && (c == 10);
            if (bus4.out_valid) begin
                n_valid++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (busy4 !== bus4.out_valid) busy_bad++;
            if (done4) begin
                n_done++;
                done_cyc = c;
            end
            if (prev_stall && cur4() !== prev) stall_bad++;
            bus4.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus4.out_valid && bus4.out_ready) got4.push_back(cur4());
            prev_stall = bus4.out_valid && !bus4.out_ready;
            prev = cur4();
        end
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        skip4  = 1'b0;
        start4 = start_in_done;
        @(negedge clk);
        check("post_done_idle", {done4, bus4.out_valid, busy4}, 32'd0);
    endtask

    task automatic cmp_beats(input string tag, input bit skip);
        int n_exp;
        n_exp = skip ? exp_skip.size() : exp_full.size();
        check({tag, "_n_beats"}, got4.size(), n_exp);
        for (int i = 0; i < n_exp && i < got4.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), got4[i], skip ? exp_skip[i] : exp_full[i]);
        end
    endtask

    initial begin
        int c, n, nload, bad;
        logic [31:0] v2, v8;

        build_exp();
        rst_n = 1'b0;
        start4 = 0; skip4 = 0; start2 = 0; skip2 = 0; start8 = 0; skip8 = 0;
        bus4.out_ready = 1'b1; bus2.out_ready = 1'b1; bus8.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_flags", {bus4.out_valid, busy4, done4, bus4.load_phase, bus4.last_in_stage}, 32'd0);
        check("rst_fields", {bus4.stage, bus4.addr_a, bus4.addr_b, bus4.twiddle}, 32'd0);
        check("rst_fields8", {bus8.out_valid, bus8.addr_a, bus8.addr_b, bus8.twiddle}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // full sequence, ready always high
        collect4(1'b0, 1'b0, 1'b0, 1'b0);
        check("full_first_valid", first_v, 32'd1);
        check("full_last_valid", last_v, 32'd48);
        check("full_n_valid", n_valid, 32'd48);
        check("full_done_cycle", done_cyc, 32'd49);
        check("full_busy_eq_valid", busy_bad, 32'd0);
        check("load_idx1", got4[1], pack4(1'b1, 1'b0, 2'd0, 4'd8, 4'd1, 3'd0));
        check("load_idx3", got4[3], pack4(1'b1, 1'b0, 2'd0, 4'd12, 4'd3, 3'd0));
        cmp_beats("full", 1'b0);

        // COMPUTE only
        collect4(1'b1, 1'b0, 1'b0, 1'b0);
        check("skip_done_cycle", done_cyc, 32'd33);
        check("s0j1", got4[1],  pack4(1'b0, 1'b0, 2'd0, 4'd2, 4'd3, 3'd0));
        check("s1j1", got4[9],  pack4(1'b0, 1'b0, 2'd1, 4'd1, 4'd3, 3'd4));
        check("s2j5", got4[21], pack4(1'b0, 1'b0, 2'd2, 4'd9, 4'd13, 3'd2));
        check("s3j5", got4[29], pack4(1'b0, 1'b0, 2'd3, 4'd5, 4'd13, 3'd5));
        for (int s = 0; s < 4; s++)
            check($sformatf("last_s%0d", s), 32'(got4[s * 8 + 7][13]), 32'd1);
        cmp_beats("skip", 1'b1);

        // backpressure
        collect4(1'b0, 1'b1, 1'b0, 1'b0);
        check("bp_stall_stable", stall_bad, 32'd0);
        check("bp_n_done", n_done, 32'd1);
        cmp_beats("bp", 1'b0);

        // start while busy and start in the DONE cycle are ignored
        collect4(1'b0, 1'b0, 1'b1, 1'b1);
        check("busy_start_done_cycle", done_cyc, 32'd49);
        cmp_beats("busy_start", 1'b0);
        // start is still high here and now seen in IDLE
        collect4(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_first_valid", first_v, 32'd1);
        check("restart_done_cycle", done_cyc, 32'd49);
        cmp_beats("restart", 1'b0);

        // asynchronous reset during stage 2
        skip4 = 1'b1; start4 = 1'b1; bus4.out_ready = 1'b1;
        c = 0;
        while (!(bus4.out_valid && bus4.stage == 2'd2) && c < 100) begin
            @(negedge clk);
            c++;
            start4 = 1'b0;
        end
        check("reached_s2", 32'(bus4.stage), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", {bus4.out_valid, busy4, done4, bus4.load_phase, bus4.last_in_stage}, 32'd0);
        check("arst_fields", {bus4.stage, bus4.addr_a, bus4.addr_b, bus4.twiddle}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done4 || bus4.out_valid) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done4 || bus4.out_valid) bad++;
        end
        check("arst_no_done", bad, 32'd0);
        skip4 = 1'b0;
        collect4(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_done_cycle", done_cyc, 32'd49);
        cmp_beats("post_rst", 1'b0);

        // N = 4
        skip2 = 1'b0; start2 = 1'b1; c = 0; n = 0; v2 = '0;
        while (!done2 && c < 100) begin
            @(negedge clk);
            c++;
            start2 = 1'b0;
            if (bus2.out_valid) begin
                if (n == 7) v2 = {bus2.stage, bus2.addr_a, bus2.addr_b, bus2.twiddle};
                n++;
            end
        end
        check("n4_beats", n, 32'd8);
        check("n4_s1j1", v2, {1'b1, 2'd1, 2'd3, 1'b1});
        check("n4_done", 32'(done2), 32'd1);

        // N = 256
        skip8 = 1'b0; start8 = 1'b1; c = 0; n = 0; nload = 0; v8 = '0;
        while (!done8 && c < 2000) begin
            @(negedge clk);
            c++;
            start8 = 1'b0;
            if (bus8.out_valid) begin
                n++;
                if (bus8.load_phase) nload++;
                v8 = {bus8.last_in_stage, bus8.stage, bus8.addr_a, bus8.addr_b, bus8.twiddle};
            end
        end
        check("n256_beats", n, 32'd1280);
        check("n256_load_beats", nload, 32'd256);
        check("n256_final", v8, {1'b1, 3'd7, 8'd127, 8'd255, 7'd127});
        check("n256_done", 32'(done8), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
Parametrised radix-2 in-place DIT FFT address sequencer. It supersedes the combinational per-stage index mapping with a self-running generator. It emits an optional bit-reversed load pass, then every butterfly of every stage as {addr_a, addr_b, twiddle} beats on a valid/ready stream. It sits between the FFT control FSM and the sample RAM / twiddle ROM.

Parameters:
LOG2N, 4, log2 of FFT length N; legal range 2..12; N = 2**LOG2N.
SW, derived (localparam), stage field width = max(1, clog2(LOG2N)).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sequence; sampled only in IDLE
skip_load  in  1  sampled with start; 1 = skip LOAD pass, go straight to COMPUTE
out_valid  out  1  current beat is valid
out_ready  in  1  consumer accepts beat when out_valid & out_ready
load_phase  out  1  1 = beat belongs to LOAD pass
stage  out  SW  current butterfly stage, 0..LOG2N-1; 0 during LOAD
addr_a  out  LOG2N  LOAD: bitrev(idx); COMPUTE: top butterfly address
addr_b  out  LOG2N  LOAD: idx; COMPUTE: bottom butterfly address
twiddle  out  LOG2N-1  twiddle ROM index; 0 during LOAD
last_in_stage  out  1  high on final beat of the LOAD pass or of each stage
busy  out  1  high in LOAD and COMPUTE
done  out  1  one-cycle pulse after the final COMPUTE beat is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; counters 0; out_valid, load_phase, busy, done, last_in_stage = 0; stage/addr_a/addr_b/twiddle = 0. Reset mid-sequence aborts immediately. No beat is completed; no done pulse.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE: start=1 -> LOAD (skip_load=0) or COMPUTE (skip_load=1). Counters are cleared on the same edge. start is ignored in every other state.
- Latency: the first beat is valid in the cycle after start is sampled.
- LOAD: idx counts 0..N-1. load_phase=1. addr_a = idx with bits reversed over LOG2N bits; addr_b = idx.
  - Advance on accept only.
  - Accepting idx=N-1 (last_in_stage=1) -> COMPUTE with s=0, j=0.
- COMPUTE: stage s = 0..LOG2N-1; butterfly j = 0..N/2-1.
  - h = 2**s; pos = j mod h; grp = j >> s.
  - addr_a = grp*2h + pos; addr_b = addr_a + h.
  - twiddle = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - last_in_stage = (j == N/2-1).
  - On accept: j increments. At j=N/2-1, j wraps to 0 and s increments.
  - Accept at s=LOG2N-1, j=N/2-1 -> DONE.
- DONE: done=1, out_valid=0, busy=0 for exactly one cycle, then IDLE.
  - start in the DONE cycle is ignored.
  - start in the following (IDLE) cycle is honoured.
- Handshake:
  - out_valid=1 throughout LOAD and COMPUTE.
  - With out_valid=1 and out_ready=0, all outputs hold stable. No beat is skipped or duplicated.
  - out_ready is don't-care when out_valid=0.
- Beat count per sequence: N (LOAD, unless skipped) + LOG2N*N/2 (COMPUTE).
- Outputs are registered state plus combinational decode of the counters; there are no combinational paths from out_ready to outputs other than the state advance.

Test Plan:
- LOG2N=4, skip_load=0, out_ready=1 continuously; start pulsed at cycle 0:
  - out_valid is high cycles 1..48 (16 LOAD + 32 COMPUTE beats).
  - done is high at cycle 49 only.
  - LOAD beat idx=1 gives addr_a=8, addr_b=1; idx=3 gives addr_a=12, addr_b=3.
- COMPUTE values, LOG2N=4, skip_load=1:
  - s=0, j=1: a=2, b=3, tw=0.
  - s=1, j=1: a=1, b=3, tw=4.
  - s=2, j=5: a=9, b=13, tw=2.
  - s=3, j=5: a=5, b=13, tw=5.
  - last_in_stage asserts on j=7 of every stage.
- Backpressure: toggle out_ready pseudo-randomly. The scoreboard sees exactly 48 accepted beats, in order, identical to the ready=1 run. Outputs stay stable on every stalled cycle.
- Reset mid-operation: drop rst_n during COMPUTE s=2, asynchronously between clock edges.
  - All outputs are 0 immediately; no done pulse follows.
  - After release, start runs a full correct 48-beat sequence.
- start while busy, and start in the DONE cycle: both are ignored (beat count unchanged); a start one cycle after done begins a new sequence.
- LOG2N=2 and LOG2N=8 builds:
  - N=4 gives 4+4 beats; s=1, j=1: a=1, b=3, tw=1.
  - N=256 gives 256+1024 beats.
  - Final beat of the last stage is a=127, b=255, tw=127.
